// File: rtl/logic_gate_pipe_if.sv
// ============================================================================
// Module      : logic_gate_pipe_if
// Description : Operand/result handshake bundle for logic_gate_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface logic_gate_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [15:0]      op_count;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, op_count
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, op_count
    );
endinterface

`default_nettype wire

// File: rtl/logic_gate_pipe.sv
// ============================================================================
// Module      : logic_gate_pipe
// Description : Bitwise AND/OR/XOR/NAND unit feeding a DEPTH-entry result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_gate_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    logic_gate_pipe_if.slave   bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH) + 1;

    localparam logic [1:0] c_OP_AND  = 2'b00;
    localparam logic [1:0] c_OP_OR   = 2'b01;
    localparam logic [1:0] c_OP_XOR  = 2'b10;

    // Each entry carries {zero, result}
    logic [WIDTH:0]      r_mem [DEPTH];
    logic [c_AW-1:0]     r_wptr;
    logic [c_AW-1:0]     r_rptr;
    logic [c_CW-1:0]     r_count;
    logic [WIDTH-1:0]    r_last;
    logic                r_last_zero;
    logic [15:0]         r_op_count;

    logic [WIDTH-1:0]    w_calc;
    logic [WIDTH:0]      w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    always_comb begin
        w_calc = '0;
        case (bus.op)
            c_OP_AND: w_calc = bus.a & bus.b;
            c_OP_OR:  w_calc = bus.a | bus.b;
            c_OP_XOR: w_calc = bus.a ^ bus.b;
            default:  w_calc = ~(bus.a & bus.b);
        endcase
    end

    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Held low while rst is high so no transfer is offered during reset
    assign bus.in_ready = !rst && !w_full;

    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = !w_empty && bus.out_ready;

    assign w_head        = r_mem[r_rptr];
    assign bus.out_valid = !w_empty;
    assign bus.result    = w_empty ? r_last      : w_head[WIDTH-1:0];
    assign bus.zero      = w_empty ? r_last_zero : w_head[WIDTH];
    assign bus.op_count  = r_op_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {(w_calc == '0), w_calc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_last      <= '0;
            r_last_zero <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            // The popped entry is remembered so outputs hold once the FIFO drains
            if (w_pop) begin
                r_rptr      <= r_rptr + c_AW'(1);
                r_last      <= w_head[WIDTH-1:0];
                r_last_zero <= w_head[WIDTH];
                if (r_op_count != 16'hFFFF) begin
                    r_op_count <= r_op_count + 16'd1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
// ============================================================================
// Module      : tb_logic_gate_pipe
// Description : Randomized and directed bench for logic_gate_pipe (WIDTH=4, DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_gate_pipe;

    localparam int c_WIDTH = 4;
    localparam int c_DEPTH = 2;

    logic clk;
    logic rst;

    logic_gate_pipe_if #(.WIDTH(c_WIDTH)) bus ();

    logic_gate_pipe #(.WIDTH(c_WIDTH), .DEPTH(c_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: queue of {zero, result}, last presented value, transfer count
    logic [c_WIDTH:0] m_q [$];
    logic [c_WIDTH:0] m_last;
    int               m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_WIDTH-1:0] ref_op(input logic [c_WIDTH-1:0] a,
                                                  input logic [c_WIDTH-1:0] b,
                                                  input logic [1:0] op);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // One clock: drive inputs, check in_ready, apply edge to the model, check outputs
    task automatic cycle(input logic iv, input logic [c_WIDTH-1:0] a, input logic [c_WIDTH-1:0] b,
                         input logic [1:0] op, input logic ordy, input logic r);
        logic             exp_rdy;
        logic [c_WIDTH-1:0] res;
        logic [c_WIDTH:0] head;
        rst           = r;
        bus.in_valid  = iv;
        bus.a         = a;
        bus.b         = b;
        bus.op        = op;
        bus.out_ready = ordy;
        #1;
        exp_rdy = !r && (m_q.size() < c_DEPTH);
        check("in_ready", bus.in_ready, exp_rdy);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            res = ref_op(a, b, op);
            if (m_q.size() > 0 && ordy) begin
                m_last = m_q.pop_front();
                if (m_cnt < 65535) m_cnt++;
            end
            if (iv && exp_rdy) m_q.push_back({(res == 0), res});
        end
        @(negedge clk);
        head = (m_q.size() > 0) ? m_q[0] : m_last;
        check("out_valid", bus.out_valid, m_q.size() > 0);
        check("result", bus.result, head[c_WIDTH-1:0]);
        check("zero", bus.zero, head[c_WIDTH]);
        check("op_count", bus.op_count, m_cnt);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        bus.out_ready = 1'b0;
        m_last = '0;
        m_cnt = 0;
        @(negedge clk);

        // Reset
        cycle(1, 4'hF, 4'hF, 2'd1, 1, 1);
        cycle(1, 4'hF, 4'hF, 2'd1, 1, 1);
        check("rst_result", bus.result, 0);

        // Four operations on the same operands, drained every cycle
        cycle(1, 4'b1100, 4'b1010, 2'd0, 1, 0);
        check("and_lit", bus.result, 4'b1000);
        cycle(1, 4'b1100, 4'b1010, 2'd1, 1, 0);
        check("or_lit", bus.result, 4'b1110);
        cycle(1, 4'b1100, 4'b1010, 2'd2, 1, 0);
        check("xor_lit", bus.result, 4'b0110);
        cycle(1, 4'b1100, 4'b1010, 2'd3, 1, 0);
        check("nand_lit", bus.result, 4'b0111);
        cycle(1, 4'b0101, 4'b1010, 2'd0, 1, 0);
        check("zero_lit", {bus.zero, bus.result}, 5'b10000);
        cycle(0, 4'h0, 4'h0, 2'd0, 1, 0);
        check("hold_lit", {bus.out_valid, bus.result}, 5'b00000);

        // Backpressure: third pair held until the consumer drains
        cycle(1, 4'h3, 4'h5, 2'd2, 0, 0);
        cycle(1, 4'h9, 4'h6, 2'd1, 0, 0);
        cycle(1, 4'hA, 4'hC, 2'd0, 0, 0);
        check("full_rdy_lit", bus.in_ready, 0);
        cycle(1, 4'hA, 4'hC, 2'd0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 4'h0, 4'h0, 2'd0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1), 4'($urandom), 4'($urandom), 2'($urandom),
                  $urandom_range(0, 3) != 0, 0);

        // Fill, then reset mid-stream
        cycle(1, 4'h1, 4'h2, 2'd1, 0, 0);
        cycle(1, 4'h4, 4'h8, 2'd1, 0, 0);
        cycle(0, 4'h0, 4'h0, 2'd0, 0, 1);
        check("mid_rst_lit", {bus.out_valid, bus.op_count, bus.result}, 21'h0);
        cycle(1, 4'h7, 4'h7, 2'd2, 0, 0);
        cycle(0, 4'h0, 4'h0, 2'd0, 1, 0);
        cycle(0, 4'h0, 4'h0, 2'd0, 1, 0);

        // Saturation of op_count under continuous streaming
        for (int i = 0; i < 65600; i++)
            cycle(1, 4'($urandom), 4'($urandom), 2'($urandom), 1, 0);
        check("sat_lit", bus.op_count, 16'hFFFF);
        cycle(1, 4'h1, 4'h1, 2'd0, 1, 0);
        check("sat_hold_lit", bus.op_count, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 2, output buffer entries; power of two, 2..16.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 in_valid  input  1  a, b and op are valid this cycle.
REQ-006 in_ready  output  1  block can accept an operand pair this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-010 out_valid  output  1  result/zero hold a buffered result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 result  output  WIDTH  oldest buffered result.
REQ-013 zero  output  1  asserted when the presented result is all zeros.
REQ-014 op_count  output  16  number of completed output handshakes, saturating.

Function
REQ-015 Input handshake: a transfer occurs on a rising edge where in_valid=1 and in_ready=1.
REQ-016 Output handshake: a transfer occurs on a rising edge where out_valid=1 and out_ready=1.
REQ-017 On each input transfer, the block computes a bitwise op(a,b) over WIDTH bits and writes it with its zero flag into the buffer tail.
REQ-018 Latency: a result accepted on edge N is presented with out_valid=1 after edge N, i.e. one cycle, if the buffer was empty.
REQ-019 The buffer is strictly FIFO: results leave in acceptance order and none is dropped or duplicated.
REQ-020 in_ready = (occupancy < DEPTH); it is combinational from occupancy only and never depends on in_valid or out_ready.
REQ-021 When full, in_ready=0 even if out_ready=1 in the same cycle; no push occurs on that edge.
REQ-022 When empty, out_valid=0; result and zero hold their last presented values, 0 after reset.
REQ-023 Simultaneous push and pop with 0 < occupancy < DEPTH keeps occupancy unchanged.
REQ-024 Read and write pointers wrap modulo DEPTH; occupancy ranges 0..DEPTH.
REQ-025 When out_valid=1 and out_ready=0, result and zero are stable until the handshake occurs.
REQ-026 op_count increments by 1 on each output transfer and saturates at 16'hFFFF with no wrap.
REQ-027 op is captured per transfer; changing op between transfers affects only subsequent results.

Reset
REQ-028 With rst=1 on an edge: occupancy=0, pointers=0, out_valid=0, result=0, zero=0, op_count=0; the same edge performs no push or pop.
REQ-029 During reset cycles in_ready=0; in_ready is 1 on the first cycle after rst deasserts.
REQ-030 A reset asserted mid-stream discards all buffered results; no stale result appears afterwards.

Verification
REQ-031 WIDTH=4, out_ready=1, push a=4'b1100, b=4'b1010, op=00, then 01, 10, 11 -> results 1000, 1110, 0110, 0111 on consecutive cycles, 1 cycle latency, zero=0 throughout.
REQ-032 Push a=4'b0101, b=4'b1010, op=00 -> result 0000, zero=1.
REQ-033 out_ready=0, DEPTH=2, push 3 pairs -> in_ready=0 after the 2nd transfer, the 3rd is held; raise out_ready -> outputs appear in order, and in_ready=1 the cycle after the first pop.
REQ-034 Continuous in_valid=1 and out_ready=1 -> one result per cycle, occupancy constant at 1, op_count +1 per cycle.
REQ-035 Fill the buffer, then assert rst for 1 cycle -> out_valid=0, op_count=0, result=0; the next push yields only the new result.
REQ-036 Preload op_count near saturation with 65535+ output transfers, then push one more -> op_count stays 16'hFFFF.
